// File: rtl/sram_responder_if.sv
// Bundle of the core's instruction and data SRAM-style ports.
// The master drives requests and the slave returns read data.
interface sram_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/sram_responder.sv
// Unified instruction/data SRAM responder with one-cycle read latency,
// byte-enable writes and a small memory-mapped configuration-register block.
module sram_responder #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] CONF_HI = 16'h1faf
) (
  input  logic               clk,
  input  logic               resetn,
  sram_responder_if.slave    bus,
  input  logic [15:0]        switch_in,
  output logic [15:0]        led_out,
  output logic [31:0]        num_out,
  output logic               wr_err
);

  localparam logic [15:0] OFF_LED    = 16'h8000;
  localparam logic [15:0] OFF_SWITCH = 16'h8004;
  localparam logic [15:0] OFF_NUM    = 16'h8008;
  localparam logic [15:0] OFF_TIMER  = 16'h800c;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]       mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] inst_idx_s;
  logic [ADDR_W-1:0] data_idx_s;
  logic              inst_conf_s;
  logic              data_conf_s;
  logic              inst_wr_s;
  logic              data_wr_s;
  logic              data_ram_wr_s;
  logic              led_wr_s;
  logic              num_wr_s;
  logic              timer_wr_s;
  logic              bad_wr_s;
  logic [15:0]       data_off_s;
  logic [31:0]       conf_rdata_s;
  logic [31:0]       led_merged_s;
  logic [31:0]       num_merged_s;
  logic [31:0]       timer_merged_s;
  logic              unused_ok_s;

  logic [15:0]       led_r;
  logic [31:0]       num_r;
  logic [31:0]       timer_r;
  logic              wr_err_r;
  logic [31:0]       inst_rdata_r;
  logic [31:0]       data_rdata_r;

  assign unused_ok_s = ^{bus.inst_sram_wdata, bus.inst_sram_addr[1:0], bus.data_sram_addr[1:0]};

  // Per-port address decode and write classification.
  always_comb begin
    inst_conf_s    = bus.inst_sram_en && (bus.inst_sram_addr[31:16] == CONF_HI);
    data_conf_s    = bus.data_sram_en && (bus.data_sram_addr[31:16] == CONF_HI);
    inst_idx_s     = bus.inst_sram_addr[ADDR_W+1:2];
    data_idx_s     = bus.data_sram_addr[ADDR_W+1:2];
    data_off_s     = bus.data_sram_addr[15:0];
    inst_wr_s      = bus.inst_sram_en && (bus.inst_sram_wen != 4'b0000);
    data_wr_s      = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
    data_ram_wr_s  = data_wr_s && !data_conf_s;
    led_wr_s       = data_wr_s && data_conf_s && (data_off_s == OFF_LED);
    num_wr_s       = data_wr_s && data_conf_s && (data_off_s == OFF_NUM);
    timer_wr_s     = data_wr_s && data_conf_s && (data_off_s == OFF_TIMER);
    // SWITCH and every unmapped offset are not writable.
    bad_wr_s       = data_wr_s && data_conf_s && !(led_wr_s || num_wr_s || timer_wr_s);
    led_merged_s   = byte_merge({16'h0000, led_r}, bus.data_sram_wdata, bus.data_sram_wen);
    num_merged_s   = byte_merge(num_r, bus.data_sram_wdata, bus.data_sram_wen);
    timer_merged_s = byte_merge(timer_r, bus.data_sram_wdata, bus.data_sram_wen);
  end

  // Configuration-region read mux.
  always_comb begin
    conf_rdata_s = 32'h0000_0000;
    case (data_off_s)
      OFF_LED:    conf_rdata_s = {16'h0000, led_r};
      OFF_SWITCH: conf_rdata_s = {16'h0000, switch_in};
      OFF_NUM:    conf_rdata_s = num_r;
      OFF_TIMER:  conf_rdata_s = timer_r;
      default:    conf_rdata_s = 32'h0000_0000;
    endcase
  end

  // RAM byte writes; contents survive reset, requests during reset are dropped.
  always_ff @(posedge clk) begin
    if (resetn && data_ram_wr_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wen[b]) begin
          mem[data_idx_s][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data registers: old word on collision, hold when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_rdata_r <= 32'h0000_0000;
      data_rdata_r <= 32'h0000_0000;
    end else begin
      if (bus.inst_sram_en) begin
        inst_rdata_r <= inst_conf_s ? 32'h0000_0000 : mem[inst_idx_s];
      end
      if (bus.data_sram_en) begin
        data_rdata_r <= data_conf_s ? conf_rdata_s : mem[data_idx_s];
      end
    end
  end

  // Configuration registers, free-running timer and sticky error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_r    <= 16'h0000;
      num_r    <= 32'h0000_0000;
      timer_r  <= 32'h0000_0000;
      wr_err_r <= 1'b0;
    end else begin
      if (led_wr_s) begin
        led_r <= led_merged_s[15:0];
      end
      if (num_wr_s) begin
        num_r <= num_merged_s;
      end
      if (timer_wr_s) begin
        timer_r <= timer_merged_s;
      end else begin
        timer_r <= timer_r + 32'd1;
      end
      if (inst_wr_s || bad_wr_s) begin
        wr_err_r <= 1'b1;
      end
    end
  end

  assign bus.inst_sram_rdata = inst_rdata_r;
  assign bus.data_sram_rdata = data_rdata_r;
  assign led_out             = led_r;
  assign num_out             = num_r;
  assign wr_err              = wr_err_r;

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the CPU core's two SRAM-style ports (instruction and data): services the `*_sram_*` signals the core drives, with fixed one-cycle read latency, byte-enable writes and a small memory-mapped configuration-register region. It sits beside the CPU core in the SoC top and replaces the external instruction and data SRAMs plus the configuration registers for simulation and FPGA bring-up. The block is unified: both ports address the same storage array.

## Interface
- `ADDR_W`, 14: word-index width of the RAM array, giving 2^ADDR_W 32-bit words.
- `CONF_HI`, 16'h1faf: value of `addr[31:16]` that selects the configuration-register region.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `inst_sram_en`  in  1  instruction-port request.
- `inst_sram_wen`  in  4  instruction-port byte enables. Must be 0; any non-zero value is an error.
- `inst_sram_addr`  in  32  instruction-port byte address.
- `inst_sram_wdata`  in  32  ignored.
- `inst_sram_rdata`  out  32  instruction read data.
- `data_sram_en`  in  1  data-port request.
- `data_sram_wen`  in  4  data-port byte enables; bit i writes byte i, i.e. `wdata[8i+7:8i]`.
- `data_sram_addr`  in  32  data-port byte address.
- `data_sram_wdata`  in  32  data-port write data.
- `data_sram_rdata`  out  32  data read data.
- `switch_in`  in  16  board switches, sampled by reads.
- `led_out`  out  16  LED register.
- `num_out`  out  32  seven-segment number register.
- `wr_err`  out  1  sticky: set by a write on the instruction port or a write to a read-only/unmapped config offset.

## Operation
- **Address decode**, for each port independently:
  - Config hit: `en && addr[31:16]==CONF_HI`.
  - Otherwise RAM, word index `addr[ADDR_W+1:2]`. Upper bits are ignored, so the array aliases; `addr[1:0]` is ignored.
- **RAM behaviour**
  - Data-port write: with `en=1` and `wen!=0`, only the enabled bytes are updated.
  - A data-port write does not return write data; `data_sram_rdata` then carries the pre-write word (read-before-write).
  - Instruction port: read-only. An `inst_sram_wen!=0` with `en=1` sets `wr_err` and does not modify memory; the read still occurs.
- **Config region**, offset `addr[15:0]`, accessed from the data port only; instruction-port config hits return 0.
  - 0x8000 LED: RW, bits [15:0]; upper bits read 0.
  - 0x8004 SWITCH: RO, returns `{16'b0, switch_in}`. A write sets `wr_err`.
  - 0x8008 NUM: RW, 32 bits.
  - 0x800c TIMER: RW, 32 bits. Increments by 1 every cycle and wraps 0xffffffff→0. A write loads the byte-merged value, and that cycle's increment is suppressed.
  - Any other offset reads 0. A write to it is ignored and sets `wr_err`.
  - Byte enables apply to the RW registers.
- **Reset**, when `resetn==0` at a clock edge:
  - `inst_sram_rdata`, `data_sram_rdata`, `led_out`, `num_out`, TIMER and `wr_err` all become 0.
  - RAM contents are not reset.
  - Requests presented in a reset cycle are discarded: no write, and read data is 0.
- **Same-address collision**: a data-port write and an instruction-port read to the same word in the same cycle give the instruction port the old word. The write is visible from the following cycle.

## Timing
- Read latency is exactly 1 cycle. For a request with `en=1` at edge N, `rdata` is valid after edge N and stays stable until the next edge with `en=1` on that port.
- With `en=0`, `rdata` holds its previous value.
- There is no backpressure and no stall: every request is accepted, one per port per cycle, back-to-back.
- A write at edge N is visible to a read issued at edge N+1; that read's data appears after N+2.
- TIMER read data is the value before that edge's update. Reads at consecutive edges with no intervening write differ by exactly 1.
- `wr_err` is set at the edge of the offending request and clears only on reset.
- `led_out` and `num_out` change the cycle after the write edge and are driven from registers.

## Test plan
- **Reset then RAM write/read.** Write 0x12345678, `wen=4'hf`, to 0x00000100, then read 0x00000100 on both ports → both `rdata`=0x12345678 one cycle after the read; `wr_err`=0.
- **Byte enables and collision.**
  - Write 0xAABBCCDD with `wen=4'b0101` over 0x12345678 → word reads 0x12BB56DD.
  - Same cycle, an instruction read of that word → returns 0x12345678.
- **Config registers.**
  - Write 0xffff_a5a5 to LED 0x1faf8000 → `led_out`=0xa5a5 and readback 0x0000a5a5.
  - `switch_in`=0x00f0 → reading 0x1faf8004 gives 0x000000f0.
  - Writing 0x1faf8004 → `wr_err`=1.
- **Timer.**
  - Write TIMER=0xfffffffe → reads on the next two cycles return 0xfffffffe then 0xffffffff; the third read returns 0x00000000.
- **Instruction-port write error.** `inst_sram_wen`=4'hf to a RAM word holding 0x1 → `wr_err`=1, word still reads 0x1.
- **Reset mid-operation.**
  - Assert `resetn=0` during back-to-back reads → `rdata`, `led_out`, `num_out` and TIMER are 0 after that edge.
  - After release, RAM still holds the earlier values (0x12BB56DD at 0x100).
